// File: rtl/reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : reg_wr_arbiter
// Round-robin write-port arbiter for R0..R3 with a pending-write scoreboard.
// Rev    : 1.0
// ============================================================================
module reg_wr_arbiter #(
    parameter int NREQ = 3,
    parameter int NREG = 4,
    parameter int DW   = 16,
    parameter int AW   = 2
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREG-1:0]    reg_en,
    output logic [DW-1:0]      reg_wdata,
    input  logic               reserve_vld,
    input  logic [AW-1:0]      reserve_addr,
    output logic               reserve_ok,
    output logic [NREG-1:0]    busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   rr_ptr_d;
    logic [NREG-1:0] reg_en_q;
    logic [NREG-1:0] reg_en_d;
    logic [DW-1:0]   reg_wdata_q;
    logic [DW-1:0]   reg_wdata_d;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic            w_any;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_cand;
    logic [NREQ-1:0] w_gnt;
    logic [AW-1:0]   w_waddr;
    logic [DW-1:0]   w_wdata;
    logic [NREG-1:0] w_addr_oh;
    logic            w_reserve_ok;

    // Walk requesters starting at rr_ptr; the first active one wins.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        w_gnt  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = PW'((int'(rr_ptr_q) + i) % NREQ);
            if (!w_any && req[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
        if (!rst_b) begin
            w_any = 1'b0;
        end
        if (w_any) begin
            w_gnt[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_waddr   = req_addr[int'(w_win)*AW +: AW];
        w_wdata   = req_data[int'(w_win)*DW +: DW];
        w_addr_oh = '0;
        w_addr_oh[w_waddr] = 1'b1;
    end

    assign w_reserve_ok = rst_b & reserve_vld & ~busy_q[reserve_addr];

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        reg_en_d    = '0;
        reg_wdata_d = reg_wdata_q;
        busy_d      = busy_q;
        if (w_any) begin
            rr_ptr_d    = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
            reg_en_d    = w_addr_oh;
            reg_wdata_d = w_wdata;
            busy_d      = busy_d & ~w_addr_oh;
        end
        // Applied after the clear so a fresh reservation of the written register survives.
        if (w_reserve_ok) begin
            busy_d[reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rr_ptr_q    <= '0;
            reg_en_q    <= '0;
            reg_wdata_q <= '0;
            busy_q      <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            reg_en_q    <= reg_en_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt        = w_gnt;
    assign reg_en     = reg_en_q;
    assign reg_wdata  = reg_wdata_q;
    assign reserve_ok = w_reserve_ok;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_reg_wr_arbiter
// Scoreboard bench for reg_wr_arbiter: directed scenarios plus random traffic.
// Rev    : 1.0
// ============================================================================
module tb_reg_wr_arbiter;

    localparam int NREQ = 3;
    localparam int NREG = 4;
    localparam int DW   = 16;
    localparam int AW   = 2;

    logic               clk = 1'b0;
    logic               rst_b;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREG-1:0]    reg_en;
    logic [DW-1:0]      reg_wdata;
    logic               reserve_vld;
    logic [AW-1:0]      reserve_addr;
    logic               reserve_ok;
    logic [NREG-1:0]    busy;

    always #5 clk = ~clk;

    reg_wr_arbiter #(.NREQ(NREQ), .NREG(NREG), .DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .req          (req),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .gnt          (gnt),
        .reg_en       (reg_en),
        .reg_wdata    (reg_wdata),
        .reserve_vld  (reserve_vld),
        .reserve_addr (reserve_addr),
        .reserve_ok   (reserve_ok),
        .busy         (busy)
    );

    typedef struct packed {
        logic [NREG-1:0] en;
        logic [DW-1:0]   wd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference state: priority index, reservation flags, last written data.
    int          m_ptr  = 0;
    bit [3:0]    m_busy = '0;
    logic [15:0] m_wd   = '0;
    int          last_win;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit rb, input logic [2:0] rq, input logic [5:0] ad,
                        input logic [47:0] dt, input bit rv, input logic [1:0] ra);
        int          win;
        logic [2:0]  exp_gnt;
        bit          exp_ok;
        logic [3:0]  exp_en;
        logic [1:0]  wa;
        @(negedge clk);
        chk("busy", 64'(busy), 64'(m_busy));
        rst_b        = rb;
        req          = rq;
        req_addr     = ad;
        req_data     = dt;
        reserve_vld  = rv;
        reserve_addr = ra;
        #1;
        win = -1;
        if (rb) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (win < 0 && rq[idx]) win = idx;
            end
        end
        exp_gnt = '0;
        if (win >= 0) exp_gnt[win] = 1'b1;
        exp_ok = rb && rv && !m_busy[ra];
        chk("gnt", 64'(gnt), 64'(exp_gnt));
        chk("reserve_ok", 64'(reserve_ok), 64'(exp_ok));
        exp_en = '0;
        if (!rb) begin
            m_ptr  = 0;
            m_busy = '0;
            m_wd   = '0;
        end else begin
            if (win >= 0) begin
                wa         = ad[win*AW +: AW];
                m_ptr      = (win + 1) % NREQ;
                exp_en[wa] = 1'b1;
                m_wd       = dt[win*DW +: DW];
                m_busy[wa] = 1'b0;
            end
            if (exp_ok) m_busy[ra] = 1'b1;
        end
        exp_q.push_back('{en: exp_en, wd: m_wd});
        last_win = win;
    endtask

    // Registered write port monitor, one expectation per clock edge.
    initial begin
        exp_t e;
        @(negedge clk);
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: got reg_en=%0h with no expectation queued", reg_en);
            end else begin
                e = exp_q.pop_front();
                chk("reg_en", 64'(reg_en), 64'(e.en));
                chk("reg_wdata", 64'(reg_wdata), 64'(e.wd));
            end
        end
    end

    bit          pend[NREQ];
    logic [1:0]  pa[NREQ];
    logic [15:0] pd[NREQ];

    initial begin
        logic [2:0]  rq;
        logic [5:0]  ad;
        logic [47:0] dt;
        rst_b = 1'b0; req = '0; req_addr = '0; req_data = '0;
        reserve_vld = 1'b0; reserve_addr = '0;

        // Reset with all requesters active, then first grant to requester 0.
        step(0, 3'b111, 6'b10_01_00, 48'h3333_2222_1111, 1, 2'd1);
        step(0, 3'b111, 6'b10_01_00, 48'h3333_2222_1111, 1, 2'd1);
        // Round-robin 0,1,2,0 with each winner dropping for one cycle.
        step(1, 3'b111, 6'b10_01_00, 48'h3333_2222_1111, 0, 2'd0);
        step(1, 3'b110, 6'b10_01_00, 48'h3333_2222_1111, 0, 2'd0);
        step(1, 3'b101, 6'b10_01_00, 48'h3333_2222_4444, 0, 2'd0);
        step(1, 3'b011, 6'b10_01_00, 48'h3333_5555_4444, 0, 2'd0);
        step(1, 3'b010, 6'b10_01_00, 48'h3333_5555_4444, 0, 2'd0);
        step(1, 3'b000, 6'b00_00_00, 48'h0, 0, 2'd0);
        // Latency/data: requester 1 writes R2 with BEEF.
        step(1, 3'b010, 6'b00_10_00, 48'h0000_BEEF_0000, 0, 2'd0);
        step(1, 3'b000, 6'b00_00_00, 48'h0, 0, 2'd0);
        step(1, 3'b000, 6'b00_00_00, 48'h0, 0, 2'd0);
        // Scoreboard: reserve R3, refuse second, write R3 clears it.
        step(1, 3'b000, 6'b00_00_00, 48'h0, 1, 2'd3);
        step(1, 3'b000, 6'b00_00_00, 48'h0, 1, 2'd3);
        step(1, 3'b001, 6'b00_00_11, 48'h0000_0000_A5A5, 1, 2'd3);
        step(1, 3'b000, 6'b00_00_00, 48'h0, 0, 2'd0);
        // Simultaneous write and reservation of non-busy R1.
        step(1, 3'b100, 6'b01_00_00, 48'h1234_0000_0000, 1, 2'd1);
        step(1, 3'b000, 6'b00_00_00, 48'h0, 0, 2'd0);
        // Reset right after a grant to R0.
        step(1, 3'b001, 6'b00_00_00, 48'h0000_0000_C0DE, 1, 2'd2);
        step(0, 3'b000, 6'b00_00_00, 48'h0, 0, 2'd0);
        step(1, 3'b000, 6'b00_00_00, 48'h0, 0, 2'd0);

        // Random traffic honouring the hold-until-granted handshake.
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom % 3) != 0) begin
                    pend[i] = 1'b1;
                    pa[i]   = 2'($urandom);
                    pd[i]   = 16'($urandom);
                end
                rq[i]          = pend[i];
                ad[i*AW +: AW] = pend[i] ? pa[i] : 2'($urandom);
                dt[i*DW +: DW] = pend[i] ? pd[i] : 16'($urandom);
            end
            step(($urandom % 64) != 0, rq, ad, dt, ($urandom % 2) == 1, 2'($urandom));
            if (last_win >= 0) pend[last_win] = 1'b0;
        end

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
